spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per SPI word.
REQ-002 Parameter CPOL, default 0: SCLK idle level; the leading edge is the transition away from CPOL.
REQ-003 Parameter CPHA, default 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.
REQ-004 clk  input  1  system clock; the block has one clock only, and all logic is clocked on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 SCLK  input  1  serial clock from the master, asynchronous to clk.
REQ-007 CS  input  1  chip select from the master, active-low, asynchronous to clk.
REQ-008 MOSI  input  1  serial data from the master, MSB first.
REQ-009 MISO  output  1  serial data to the master, MSB first.
REQ-010 tx_data  input  DATA_WIDTH  word to send in the next transfer.
REQ-011 tx_load  input  1  single-cycle strobe that captures tx_data into the tx holding register.
REQ-012 rx_data  output  DATA_WIDTH  last complete received word.
REQ-013 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-014 busy  output  1  high while synchronized CS is low.
REQ-015 frame_err  output  1  one-cycle pulse when CS deasserts with a partial word.

Function
REQ-016 SCLK, CS and MOSI shall each pass through a 2-flop synchronizer; a third flop on SCLK and CS shall provide edge detection (stage2 != stage3).
REQ-017 Operating limits: each SCLK high and low phase >= 3 clk, and CS-low to first SCLK edge >= 4 clk; behaviour outside these limits is unspecified.
REQ-018 tx_load shall write the tx holding register in any cycle, including while busy; the register keeps its value until the next tx_load.
REQ-019 On detected CS fall: bit counter <= 0, tx shift register <= holding register, busy <= 1 in the same cycle.
REQ-020 On each detected sample edge (REQ-003): rx shift register <= {rx_shift[DATA_WIDTH-2:0], MOSI_sync}; bit counter increments.
REQ-021 On each detected shift edge: tx shift register shifts left by one, LSB filled with 0.
REQ-022 CPHA=1 exception: the first leading edge of a word shall not shift the tx shift register; MISO keeps the MSB.
REQ-023 MISO shall equal tx_shift[DATA_WIDTH-1] while busy, and 0 while not busy.
REQ-024 When the sample edge brings bit counter to DATA_WIDTH: rx_data <= completed word and rx_valid = 1 in the next clk cycle; bit counter <= 0.
REQ-025 In the same cycle as REQ-024, tx shift register <= holding register, for back-to-back words within one CS frame.
REQ-026 CPHA=0, multi-word: the trailing edge after the last bit shall not shift the freshly reloaded word.
REQ-027 On detected CS rise: busy <= 0; if bit counter != 0, frame_err = 1 for one cycle; partial rx bits are discarded; rx_data is unchanged; no rx_valid.
REQ-028 SCLK edges while synchronized CS is high shall be ignored.
REQ-029 If CS rise and a sample edge are detected in the same cycle, CS rise shall take priority, and that edge shall be ignored.
REQ-030 rx_data shall hold its value until the next complete word; an unread word is overwritten without indication.

Reset
REQ-031 While rst = 1, asynchronously: MISO = 0, rx_data = 0, rx_valid = 0, busy = 0, frame_err = 0, bit counter = 0, tx holding and shift registers = 0.
REQ-032 Synchronizer stages shall reset to CS = 1 and SCLK = CPOL, so the first cycle after reset produces no spurious edge.
REQ-033 Reset asserted mid-frame shall abort the frame without rx_valid or frame_err.
REQ-034 After reset release with CS already low, the block shall stay idle until the next CS fall.

Verification
REQ-035 Mode 0, tx_load 0x5A, master (PRESCALE 4) sends 0xAC -> rx_data = 0xAC with one rx_valid pulse; master receives 0x5A.
REQ-036 Modes 1, 2 and 3, same data as REQ-035 -> identical rx_data, MISO bit sequence and rx_valid count.
REQ-037 Two words 0x11 then 0x22 in one CS frame, tx_load 0xC3 then 0x3C loaded mid-frame -> two rx_valid pulses, rx_data 0x11 then 0x22; MISO 0xC3 then 0x3C.
REQ-038 CS deasserted after 3 bits -> frame_err pulse, no rx_valid, rx_data unchanged; next full frame received correctly.
REQ-039 rst pulsed after 5 bits -> all outputs at reset values; subsequent frame with 0xF0 -> rx_data = 0xF0.
REQ-040 SCLK toggled with CS high, and random MOSI -> no rx_valid, MISO = 0, busy = 0.

Source files
------------

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus the local tx/rx side of an SPI slave
// Ports: SCLK, CS (active-low), MOSI from the master; MISO back to it;
// tx_data/tx_load load the next word; rx_data/rx_valid report a received word;
// busy follows chip select; frame_err flags a frame cut short mid-word.
// master modport drives the pins and tx side, slave modport is the spi_slave view.
interface spi_slave_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  SCLK;
    logic                  CS;
    logic                  MOSI;
    logic                  MISO;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_load;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  busy;
    logic                  frame_err;

    modport master (
        output SCLK, CS, MOSI, tx_data, tx_load,
        input  MISO, rx_data, rx_valid, busy, frame_err
    );

    modport slave (
        input  SCLK, CS, MOSI, tx_data, tx_load,
        output MISO, rx_data, rx_valid, busy, frame_err
    );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: SPI slave, all modes via CPOL/CPHA, oversampled in the clk domain
// Ports: clk system clock, rst async active-high reset, bus spi_slave_if.slave
// carrying SCLK/CS/MOSI/MISO pins and the tx_data/tx_load, rx_data/rx_valid,
// busy and frame_err local signals.
module spi_slave #(
    parameter int DATA_WIDTH = 8,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0
) (
    input logic       clk,
    input logic       rst,
    spi_slave_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [2:0]            sclk_s, cs_s;
    logic [1:0]            mosi_s, vld;
    logic                  armed, busy_r, hold_nx, rx_valid_r, frame_err_r;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-2:0] rx_shift;
    logic [DATA_WIDTH-1:0] tx_shift, tx_hold, rx_data_r, rx_next;
    logic                  sclk_rise, sclk_fall, lead, trail, smp, shf, cs_fall, cs_rise, last;

    assign sclk_rise = sclk_s[1] & ~sclk_s[2];
    assign sclk_fall = ~sclk_s[1] & sclk_s[2];
    assign lead      = CPOL ? sclk_fall : sclk_rise;
    assign trail     = CPOL ? sclk_rise : sclk_fall;
    assign smp       = CPHA ? trail : lead;
    assign shf       = CPHA ? lead : trail;
    assign cs_fall   = ~cs_s[1] & cs_s[2];
    assign cs_rise   = cs_s[1] & ~cs_s[2];
    assign last      = bit_cnt == CW'(DATA_WIDTH - 1);
    assign rx_next   = {rx_shift, mosi_s[1]};

    assign bus.MISO      = busy_r & tx_shift[DATA_WIDTH-1];
    assign bus.rx_data   = rx_data_r;
    assign bus.rx_valid  = rx_valid_r;
    assign bus.busy      = busy_r;
    assign bus.frame_err = frame_err_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s      <= {3{CPOL}};
            cs_s        <= 3'b111;
            mosi_s      <= '0;
            vld         <= '0;
            armed       <= 1'b0;
            busy_r      <= 1'b0;
            hold_nx     <= 1'b0;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_hold     <= '0;
            rx_data_r   <= '0;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            sclk_s      <= {sclk_s[1:0], bus.SCLK};
            cs_s        <= {cs_s[1:0], bus.CS};
            mosi_s      <= {mosi_s[0], bus.MOSI};
            // vld marks when cs_s[1] holds a real sample rather than its reset value;
            // a frame may only start after CS has genuinely been seen high.
            vld         <= {vld[0], 1'b1};
            armed       <= armed | (vld[1] & cs_s[1]);
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            if (bus.tx_load)
                tx_hold <= bus.tx_data;
            if (busy_r && cs_rise) begin
                busy_r      <= 1'b0;
                frame_err_r <= bit_cnt != '0;
                bit_cnt     <= '0;
            end else if (!busy_r && armed && cs_fall) begin
                busy_r   <= 1'b1;
                bit_cnt  <= '0;
                tx_shift <= tx_hold;
                hold_nx  <= CPHA;
            end else if (busy_r && smp) begin
                rx_shift <= rx_next[DATA_WIDTH-2:0];
                if (last) begin
                    bit_cnt    <= '0;
                    rx_data_r  <= rx_next;
                    rx_valid_r <= 1'b1;
                    tx_shift   <= tx_hold;
                    hold_nx    <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (busy_r && shf) begin
                // hold_nx swallows one shift edge: the CPHA=1 first leading edge of a
                // word, or the CPHA=0 trailing edge right after a word reload.
                if (hold_nx)
                    hold_nx <= 1'b0;
                else
                    tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: drives all four SPI modes in lockstep and scoreboards received words
module tb_spi_slave;
    logic clk = 1'b0;
    logic rst, cs, ph, mosi0, mosi1, tx_load;
    logic [7:0] tx_data;
    logic [3:0] miso, rxv, bsy, fe, bad;
    logic [7:0] rxd [4];
    logic [7:0] got [4];
    logic [7:0] rq [4][$];
    int fe_cnt [4];
    int total = 0;
    int pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_m
        localparam bit CP = (g / 2) == 1;
        localparam bit CH = (g % 2) == 1;
        spi_slave_if #(.DATA_WIDTH(8)) bus ();
        assign bus.SCLK    = ph ^ CP;
        assign bus.CS      = cs;
        assign bus.MOSI    = CH ? mosi1 : mosi0;
        assign bus.tx_data = tx_data;
        assign bus.tx_load = tx_load;
        assign miso[g]     = bus.MISO;
        assign rxd[g]      = bus.rx_data;
        assign rxv[g]      = bus.rx_valid;
        assign bsy[g]      = bus.busy;
        assign fe[g]       = bus.frame_err;
        spi_slave #(.DATA_WIDTH(8), .CPOL(CP), .CPHA(CH)) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s mode%0d: got %0h, want %0h", nm, m, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
    endtask

    task automatic start();
        cs = 1'b0;
        tick(8);
    endtask

    task automatic stop();
        tick(4);
        cs = 1'b1;
        tick(8);
    endtask

    // One word of nb bits, all modes at once; CPHA=0 modes read MISO at the
    // leading edge, CPHA=1 modes at the trailing edge.
    task automatic word(input logic [7:0] d, input logic [7:0] m, input int nb, input int ld_at, input logic [7:0] ld);
        for (int g = 0; g < 4; g++) begin
            got[g] = 8'h00;
            if (nb == 8) rq[g].push_back(d);
        end
        mosi0 = d[7];
        for (int i = 0; i < nb; i++) begin
            for (int g = 0; g < 4; g += 2) got[g][7-i] = miso[g];
            ph = 1'b1;
            mosi1 = d[7-i];
            if (i == ld_at) begin
                tx_data = ld;
                tx_load = 1'b1;
                tick(1);
                tx_load = 1'b0;
                tick(3);
            end else begin
                tick(4);
            end
            for (int g = 1; g < 4; g += 2) got[g][7-i] = miso[g];
            ph = 1'b0;
            if (i < 7) mosi0 = d[6-i];
            tick(4);
        end
        if (nb == 8)
            for (int g = 0; g < 4; g++) chk("miso_word", g, got[g], m);
        tick(4);
    endtask

    task automatic toggle(input int n);
        bad = 4'h0;
        repeat (2 * n) begin
            ph = ~ph;
            mosi0 = 1'($urandom_range(0, 1));
            mosi1 = 1'($urandom_range(0, 1));
            tick(4);
            bad |= bsy | miso;
        end
    endtask

    initial begin
        for (int g = 0; g < 4; g++) fe_cnt[g] = 0;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) begin
                if (fe[g]) fe_cnt[g]++;
                if (rxv[g]) begin
                    if (rq[g].size() == 0) begin
                        total++;
                        $display("FAIL rx_valid_unexpected mode%0d: got pulse with rx_data %0h, want none", g, rxd[g]);
                    end else begin
                        chk("rx_data", g, rxd[g], rq[g].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish before 2ms");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cs = 1'b1; ph = 1'b0; mosi0 = 1'b0; mosi1 = 1'b0;
        tx_data = 8'h00; tx_load = 1'b0;
        tick(3);
        for (int g = 0; g < 4; g++) begin
            chk("rst_rx_data", g, rxd[g], 0);
            chk("rst_busy", g, bsy[g], 0);
            chk("rst_miso", g, miso[g], 0);
            chk("rst_rx_valid", g, rxv[g], 0);
            chk("rst_frame_err", g, fe[g], 0);
        end
        rst = 1'b0;
        tick(6);

        load(8'h5A);
        start();
        for (int g = 0; g < 4; g++) chk("busy_in_frame", g, bsy[g], 1);
        word(8'hAC, 8'h5A, 8, -1, 8'h00);
        stop();
        for (int g = 0; g < 4; g++) begin
            chk("busy_after_frame", g, bsy[g], 0);
            chk("rx_hold_ac", g, rxd[g], 8'hAC);
        end

        load(8'hC3);
        start();
        word(8'h11, 8'hC3, 8, 3, 8'h3C);
        word(8'h22, 8'h3C, 8, -1, 8'h00);
        stop();
        for (int g = 0; g < 4; g++) chk("rx_hold_22", g, rxd[g], 8'h22);

        start();
        word(8'h55, 8'h00, 3, -1, 8'h00);
        stop();
        for (int g = 0; g < 4; g++) begin
            chk("frame_err_count", g, fe_cnt[g], 1);
            chk("rx_after_partial", g, rxd[g], 8'h22);
        end
        start();
        word(8'h96, 8'h3C, 8, -1, 8'h00);
        stop();
        for (int g = 0; g < 4; g++) chk("rx_after_recover", g, rxd[g], 8'h96);

        load(8'hA5);
        start();
        word(8'h0F, 8'h00, 5, -1, 8'h00);
        rst = 1'b1;
        tick(2);
        for (int g = 0; g < 4; g++) begin
            chk("midrst_rx_data", g, rxd[g], 0);
            chk("midrst_busy", g, bsy[g], 0);
            chk("midrst_miso", g, miso[g], 0);
        end
        rst = 1'b0;
        tick(4);
        toggle(8);
        for (int g = 0; g < 4; g++) chk("cs_low_after_rst_idle", g, bad[g], 0);
        cs = 1'b1;
        tick(8);
        for (int g = 0; g < 4; g++) chk("no_frame_err_on_rst", g, fe_cnt[g], 1);
        start();
        word(8'hF0, 8'h00, 8, -1, 8'h00);
        stop();
        for (int g = 0; g < 4; g++) chk("rx_after_rst", g, rxd[g], 8'hF0);

        toggle(16);
        for (int g = 0; g < 4; g++) chk("sclk_cs_high_idle", g, bad[g], 0);
        tick(8);
        for (int g = 0; g < 4; g++) begin
            chk("rx_queue_empty", g, rq[g].size(), 0);
            chk("frame_err_final", g, fe_cnt[g], 1);
        end

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
